// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: forwarding, load-use stall, branch flush,
// debug halt/step/resume drain FSM and saturating stall/flush event counters.
//
// state  | meaning
// RUN    | normal execution, hazards handled inline
// DRAIN  | fetch frozen, older instructions retire until drain counter expires
// HALTED | pipeline empty and frozen, waiting for step or resume
// STEP   | one cycle letting the PC instruction into D, then back to DRAIN
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [1:0]       resultsrcE,
  input  logic             pcsrcE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             dbg_halt_req,
  input  logic             dbg_step,
  input  logic             dbg_resume,
  input  logic             cnt_clr,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             dbg_halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_STEP} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_stall;

  // M-stage result is newer than W, so it wins when both match
  always_comb begin
    forwardAE = 2'b00;
    if (regwriteM && rdM != 5'd0 && rdM == rs1E)      forwardAE = 2'b10;
    else if (regwriteW && rdW != 5'd0 && rdW == rs1E) forwardAE = 2'b01;
    forwardBE = 2'b00;
    if (regwriteM && rdM != 5'd0 && rdM == rs2E)      forwardBE = 2'b10;
    else if (regwriteW && rdW != 5'd0 && rdW == rs2E) forwardBE = 2'b01;
  end

  assign lw_stall = (resultsrcE == 2'b01) && (rdE != 5'd0) &&
                    ((rdE == rs1D) || (rdE == rs2D));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_RUN: begin
        if (dbg_halt_req) begin
          state_d = S_DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end
      end
      S_DRAIN: begin
        // only bubble-free cycles move an instruction toward retirement
        if (!lw_stall && !pcsrcE) begin
          if (drain_q <= DW'(1)) begin
            state_d = S_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
      S_HALTED: begin
        if (dbg_resume)    state_d = S_RUN;
        else if (dbg_step) state_d = S_STEP;
      end
      S_STEP: begin
        state_d = S_DRAIN;
        drain_d = DW'(DRAIN_CYCLES);
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    stallF     = 1'b0;
    stallD     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    dbg_halted = 1'b0;
    case (state_q)
      S_RUN: begin
        stallF = lw_stall;
        stallD = lw_stall;
        flushD = pcsrcE;
        flushE = lw_stall | pcsrcE;
      end
      S_DRAIN: begin
        // a redirect must still load the PC so the target is not lost
        stallF = ~pcsrcE;
        stallD = lw_stall & ~pcsrcE;
        flushD = ~lw_stall | pcsrcE;
        flushE = lw_stall | pcsrcE;
      end
      S_HALTED: begin
        stallF     = 1'b1;
        stallD     = 1'b1;
        flushE     = 1'b1;
        dbg_halted = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      stallF     = 1'b0;
      stallD     = 1'b0;
      flushD     = 1'b1;
      flushE     = 1'b1;
      dbg_halted = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (lw_stall && (state_q == S_RUN || state_q == S_DRAIN) && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (pcsrcE && flush_cnt_q != '1)
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; counters built narrow so saturation is reachable.
module tb_pipeline_hazard_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0] resultsrcE;
  logic pcsrcE, regwriteM, regwriteW, dbg_halt_req, dbg_step, dbg_resume, cnt_clr;
  logic stallF, stallD, flushD, flushE, dbg_halted;
  logic [1:0] forwardAE, forwardBE;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  int pc;
  int pc_ref;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .resultsrcE(resultsrcE), .pcsrcE(pcsrcE), .rdM(rdM), .rdW(rdW),
    .regwriteM(regwriteM), .regwriteW(regwriteW), .dbg_halt_req(dbg_halt_req),
    .dbg_step(dbg_step), .dbg_resume(dbg_resume), .cnt_clr(cnt_clr),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .dbg_halted(dbg_halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // PC model: advances when not stalled, loads a fixed target on redirect
  always @(posedge clk) begin
    if (rst) pc <= 0;
    else if (!stallF) pc <= pcsrcE ? 32'h1000 : pc + 4;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    resultsrcE = 2'b00; pcsrcE = 0; regwriteM = 0; regwriteW = 0;
    dbg_halt_req = 0; dbg_step = 0; dbg_resume = 0; cnt_clr = 0;
  endtask

  task automatic chk_ctl(input string name, input logic [3:0] exp);
    // exp = {stallF, stallD, flushD, flushE}
    checks++;
    if ({stallF, stallD, flushD, flushE} !== exp) begin
      errors++;
      $display("FAIL %s: sF/sD/fD/fE got %b expected %b", name,
               {stallF, stallD, flushD, flushE}, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1; rs1E = 5; rdM = 5; regwriteM = 1;
    tick(); tick();
    chk_ctl("reset_ctl", 4'b0011);
    checks++;
    if (forwardAE !== 2'b10 || dbg_halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_fwd_halt: fwdA=%b halted=%b expected 10 0", forwardAE, dbg_halted);
    end
    rst = 0; idle();
    tick();
    chk_ctl("post_reset_ctl", 4'b0000);
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || dbg_halted !== 0) begin
      errors++;
      $display("FAIL post_reset_regs: stall=%0d flush=%0d halted=%b expected 0 0 0",
               stall_cnt, flush_cnt, dbg_halted);
    end
  endtask

  task automatic test_forward();
    logic [4:0] t_rs1E [6] = '{5, 5, 7, 9, 0, 3};
    logic [4:0] t_rs2E [6] = '{0, 0, 7, 4, 0, 3};
    logic [4:0] t_rdM  [6] = '{5, 0, 7, 4, 0, 3};
    logic       t_wM   [6] = '{1, 1, 0, 1, 1, 0};
    logic [4:0] t_rdW  [6] = '{5, 5, 7, 9, 0, 3};
    logic       t_wW   [6] = '{1, 1, 1, 1, 1, 0};
    logic [1:0] t_a    [6] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [1:0] t_b    [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      rs1E = t_rs1E[i]; rs2E = t_rs2E[i]; rdM = t_rdM[i]; regwriteM = t_wM[i];
      rdW = t_rdW[i]; regwriteW = t_wW[i];
      #1;
      checks++;
      if (forwardAE !== t_a[i] || forwardBE !== t_b[i]) begin
        errors++;
        $display("FAIL fwd_vec%0d: A=%b B=%b expected A=%b B=%b", i, forwardAE, forwardBE,
                 t_a[i], t_b[i]);
      end
    end
    idle();
  endtask

  task automatic test_load_use();
    resultsrcE = 2'b01; rdE = 3; rs2D = 3;
    #1 chk_ctl("lw_stall_run", 4'b1101);
    tick();
    idle();
    #1 chk_ctl("lw_released", 4'b0000);
    checks++;
    if (stall_cnt !== 1) begin
      errors++;
      $display("FAIL lw_stall_cnt: got %0d expected 1", stall_cnt);
    end
    resultsrcE = 2'b01; rdE = 0; rs1D = 0;
    #1 chk_ctl("lw_rd_x0", 4'b0000);
    resultsrcE = 2'b10; rdE = 3; rs1D = 3;
    #1 chk_ctl("non_load_src", 4'b0000);
    tick();
    idle();
    checks++;
    if (stall_cnt !== 1) begin
      errors++;
      $display("FAIL lw_no_incr: got %0d expected 1", stall_cnt);
    end
  endtask

  task automatic test_branch();
    pcsrcE = 1;
    #1 chk_ctl("branch_run", 4'b0011);
    tick();
    idle();
    checks++;
    if (flush_cnt !== 1) begin
      errors++;
      $display("FAIL branch_flush_cnt: got %0d expected 1", flush_cnt);
    end
  endtask

  task automatic test_halt();
    dbg_halt_req = 1;
    tick();
    dbg_halt_req = 0;
    pc_ref = pc;
    for (int i = 0; i < 4; i++) begin
      chk_ctl("drain_quiet", 4'b1010);
      checks++;
      if (dbg_halted !== 0) begin
        errors++;
        $display("FAIL drain_not_halted: cycle %0d halted=%b expected 0", i, dbg_halted);
      end
      tick();
    end
    checks++;
    if (dbg_halted !== 1 || pc !== pc_ref) begin
      errors++;
      $display("FAIL halt_reached: halted=%b pc=%0h expected 1 pc=%0h", dbg_halted, pc, pc_ref);
    end
    chk_ctl("halted_ctl", 4'b1101);
    dbg_halt_req = 1;
    tick();
    dbg_halt_req = 0;
    tick();
    checks++;
    if (dbg_halted !== 1) begin
      errors++;
      $display("FAIL halt_req_in_halted: halted=%b expected 1", dbg_halted);
    end
  endtask

  task automatic test_step();
    pc_ref = pc;
    dbg_step = 1;
    tick();
    dbg_step = 0;
    chk_ctl("step_ctl", 4'b0000);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dbg_halted !== 0) begin
        errors++;
        $display("FAIL step_not_halted: cycle %0d halted=%b expected 0", i, dbg_halted);
      end
      tick();
    end
    checks++;
    if (dbg_halted !== 1 || pc !== pc_ref + 4) begin
      errors++;
      $display("FAIL step_one_instr: halted=%b pc=%0h expected 1 pc=%0h", dbg_halted, pc,
               pc_ref + 4);
    end
  endtask

  task automatic test_step_resume_together();
    dbg_step = 1; dbg_resume = 1;
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (dbg_halted !== 0 || stallF !== 0) begin
      errors++;
      $display("FAIL step_resume_run: halted=%b stallF=%b expected 0 0", dbg_halted, stallF);
    end
  endtask

  task automatic test_drain_hazard();
    dbg_halt_req = 1;
    tick();
    // quiet cycle with a repeated halt request that must not reload the drain count
    dbg_halt_req = 1;
    tick();
    dbg_halt_req = 0;
    resultsrcE = 2'b01; rdE = 3; rs1D = 3;
    #1 chk_ctl("drain_lw", 4'b1101);
    tick();
    idle();
    pcsrcE = 1;
    #1 chk_ctl("drain_branch", 4'b0011);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dbg_halted !== 0) begin
        errors++;
        $display("FAIL drain_hz_not_halted: cycle %0d halted=%b expected 0", i, dbg_halted);
      end
      tick();
    end
    checks++;
    if (dbg_halted !== 1 || pc !== 32'h1000) begin
      errors++;
      $display("FAIL drain_hz_halt: halted=%b pc=%0h expected 1 pc=1000", dbg_halted, pc);
    end
    dbg_resume = 1;
    tick();
    idle();
    checks++;
    if (dbg_halted !== 0 || stallF !== 0) begin
      errors++;
      $display("FAIL resume: halted=%b stallF=%b expected 0 0", dbg_halted, stallF);
    end
  endtask

  task automatic test_counters();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++;
      $display("FAIL cnt_clear: stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt);
    end
    resultsrcE = 2'b01; rdE = 7; rs1D = 7; pcsrcE = 1;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (stall_cnt !== 15 || flush_cnt !== 15) begin
      errors++;
      $display("FAIL cnt_reach_max: stall=%0d flush=%0d expected 15 15", stall_cnt, flush_cnt);
    end
    tick();
    checks++;
    if (stall_cnt !== 15 || flush_cnt !== 15) begin
      errors++;
      $display("FAIL cnt_saturate: stall=%0d flush=%0d expected 15 15", stall_cnt, flush_cnt);
    end
    cnt_clr = 1;
    tick();
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++;
      $display("FAIL clr_priority: stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_drain();
    dbg_halt_req = 1;
    tick();
    dbg_halt_req = 0;
    tick();
    rst = 1;
    #1 chk_ctl("reset_in_drain", 4'b0011);
    tick();
    rst = 0;
    #1 chk_ctl("run_after_reset", 4'b0000);
    tick();
    tick();
    checks++;
    if (dbg_halted !== 0 || stallF !== 0) begin
      errors++;
      $display("FAIL reset_mid_drain: halted=%b stallF=%b expected 0 0", dbg_halted, stallF);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_halt();
    test_step();
    test_step_resume_together();
    test_drain_hazard();
    test_counters();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
